// File: rtl/mem_ext_pkg.sv
// Shared types and helpers for the masked 1R1W SRAM model.
// Holds the init FSM state type, the lane-merge function and parameter legality checks.
package mem_ext_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_init_state_e;

  // Widest word the generic merge function handles.
  localparam int unsigned MERGE_MAX_W = 64;

  // Bit i of the result takes new_w when mask lane i/gran is set, else keeps old_w.
  function automatic logic [MERGE_MAX_W-1:0] mask_merge(input logic [MERGE_MAX_W-1:0] old_w,
                                                        input logic [MERGE_MAX_W-1:0] new_w,
                                                        input logic [MERGE_MAX_W-1:0] mask,
                                                        input int unsigned gran);
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_W; i++) begin
      if (mask[6'(i / gran)]) res[i] = new_w[i];
    end
    return res;
  endfunction

  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit gran_legal(input int unsigned width, input int unsigned gran);
    return (gran != 0) && (width != 0) && (width <= MERGE_MAX_W) && ((width % gran) == 0);
  endfunction

  function automatic bit lat_legal(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/masked_sram_1r1w_if.sv
// Read/write request bus of the masked 1R1W SRAM.
// The master drives requests; the slave (the memory) returns read data and the init status.
interface masked_sram_1r1w_if #(
  parameter int unsigned AW       = 11,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MASK_SEG = 2
);
  logic [AW-1:0]       R0_addr;
  logic                R0_en;
  logic [WIDTH-1:0]    R0_data;
  logic                R0_valid;
  logic [AW-1:0]       W0_addr;
  logic                W0_en;
  logic [WIDTH-1:0]    W0_data;
  logic [MASK_SEG-1:0] W0_mask;
  logic                init_busy;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid, init_busy
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid, init_busy
  );
endinterface

// File: rtl/mem_ext_lane_merge.sv
// Combinational per-lane merge: lanes with a set mask bit take new_i, the rest keep old_i.
// Used both for read-modify-write on the array and for the read-during-write bypass.
module mem_ext_lane_merge
  import mem_ext_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MASK_GRAN = 2,
  localparam int unsigned MASK_SEG = WIDTH / MASK_GRAN
) (
  input  logic [WIDTH-1:0]    old_i,
  input  logic [WIDTH-1:0]    new_i,
  input  logic [MASK_SEG-1:0] mask_i,
  output logic [WIDTH-1:0]    merged_o
);

  always_comb begin
    merged_o = WIDTH'(mask_merge(MERGE_MAX_W'(old_i), MERGE_MAX_W'(new_i),
                                 MERGE_MAX_W'(mask_i), MASK_GRAN));
  end

endmodule

// File: rtl/masked_sram_1r1w.sv
// Single-clock 1R1W masked SRAM with zero-init sweep, 1- or 2-cycle read latency,
// optional same-address read-during-write bypass and a read-valid strobe.
module masked_sram_1r1w
  import mem_ext_pkg::*;
#(
  parameter int unsigned DEPTH         = 2048,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned MASK_GRAN     = 2,
  parameter int unsigned READ_LAT      = 1,
  parameter bit          BYPASS        = 1'b1,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  masked_sram_1r1w_if.slave  bus
);

  localparam int unsigned AW       = calc_aw(DEPTH);
  localparam int unsigned MASK_SEG = WIDTH / MASK_GRAN;

  if (!gran_legal(WIDTH, MASK_GRAN)) begin : g_bad_gran
    $fatal(1, "masked_sram_1r1w: WIDTH must be a non-zero multiple of MASK_GRAN and <= 64");
  end
  if (!lat_legal(READ_LAT)) begin : g_bad_lat
    $fatal(1, "masked_sram_1r1w: READ_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "masked_sram_1r1w: DEPTH must be >= 2");
  end

  mem_init_state_e   state_q, state_d;
  logic [AW-1:0]     init_ctr_q, init_ctr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              ready;
  logic              wr_in_range, rd_in_range;
  logic              wr_fire, init_fire, rd_fire, rd_hit;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  wr_old, wr_new, wr_word;
  logic [MASK_SEG-1:0] wr_mask;
  logic [WIDTH-1:0]  rd_word, rd_merged, rd_resp;
  logic              resp_valid;
  logic [WIDTH-1:0]  resp_data;
  logic              r0_valid_q, r0_valid_d;
  logic [WIDTH-1:0]  r0_data_q, r0_data_d;

  assign ready       = (state_q == READY);
  assign wr_in_range = 32'(bus.W0_addr) < DEPTH;
  assign rd_in_range = 32'(bus.R0_addr) < DEPTH;

  // Nothing touches the array or the read pipe while reset is held.
  assign wr_fire   = reset && ready && bus.W0_en && wr_in_range;
  assign init_fire = reset && !ready;
  assign rd_fire   = reset && ready && bus.R0_en;
  assign rd_hit    = BYPASS && wr_fire && (bus.W0_addr == bus.R0_addr);

  assign mem_we    = wr_fire || init_fire;
  assign mem_waddr = ready ? bus.W0_addr : init_ctr_q;
  assign wr_old    = mem_q[mem_waddr];
  assign wr_new    = ready ? bus.W0_data : '0;
  assign wr_mask   = ready ? bus.W0_mask : '1;

  mem_ext_lane_merge #(
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN)
  ) u_wr_merge (
    .old_i    (wr_old),
    .new_i    (wr_new),
    .mask_i   (wr_mask),
    .merged_o (wr_word)
  );

  assign rd_word = rd_in_range ? mem_q[bus.R0_addr] : '0;

  mem_ext_lane_merge #(
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN)
  ) u_byp_merge (
    .old_i    (rd_word),
    .new_i    (bus.W0_data),
    .mask_i   (bus.W0_mask),
    .merged_o (rd_merged)
  );

  assign rd_resp = rd_hit ? rd_merged : rd_word;

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= wr_word;
  end

  always_comb begin
    state_d    = state_q;
    init_ctr_d = init_ctr_q;
    if (state_q == INIT) begin
      init_ctr_d = init_ctr_q + 1'b1;
      if (32'(init_ctr_q) == DEPTH - 1) begin
        state_d    = READY;
        init_ctr_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= INIT_ON_RESET ? INIT : READY;
      init_ctr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ctr_q <= init_ctr_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;

    // Data is captured at the request edge, so later writes cannot reach it.
    always_comb begin
      s1_valid_d = rd_fire;
      s1_data_d  = rd_fire ? rd_resp : s1_data_q;
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign resp_valid = s1_valid_q;
    assign resp_data  = s1_data_q;
  end else begin : g_lat1
    assign resp_valid = rd_fire;
    assign resp_data  = rd_resp;
  end

  always_comb begin
    r0_valid_d = resp_valid;
    r0_data_d  = resp_valid ? resp_data : r0_data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r0_valid_q <= 1'b0;
      r0_data_q  <= '0;
    end else begin
      r0_valid_q <= r0_valid_d;
      r0_data_q  <= r0_data_d;
    end
  end

  assign bus.R0_data   = r0_data_q;
  assign bus.R0_valid  = r0_valid_q;
  assign bus.init_busy = (state_q == INIT);

endmodule
